// File: rtl/yuv444_to_yuv422.sv
// YCbCr 4:4:4 to 4:2:2 chroma decimator with AXI4-Stream on both sides.
// Pixel pairs share one Cb/Cr sample; a 2-entry registered queue drives the master port.
module yuv444_to_yuv422 #(
  parameter int    C_COMPONENT_WIDTH = 8,
  parameter string C_CHROMA_MODE     = "AVG"
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [3*C_COMPONENT_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tuser,
  input  logic                           s_axis_tlast,
  output logic [2*C_COMPONENT_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast
);
  localparam int W       = C_COMPONENT_WIDTH;
  localparam int EW      = 2*W + 2;  // queue entry: {chroma, y, tuser, tlast}
  localparam bit USE_AVG = (C_CHROMA_MODE != "DROP");

  typedef enum logic {EVEN, ODD} phase_t;

  phase_t            state_reg, state_next;
  logic [W-1:0]      pend_y_reg, pend_y_next;
  logic [W-1:0]      pend_cb_reg, pend_cb_next;
  logic [W-1:0]      pend_cr_reg, pend_cr_next;
  logic              pend_user_reg, pend_user_next;
  logic [EW-1:0]     q_reg [2];
  logic [EW-1:0]     q_next [2];
  logic [1:0]        count_reg, count_next;
  logic              aresetn_q_reg;

  logic [W-1:0]      in_y, in_cb, in_cr;
  logic [1:0][W-1:0] pair_even, pair_odd, chroma_filt;  // [0] = Cb, [1] = Cr
  logic              pop, accept;
  logic [1:0]        free, kept_cnt, npush;
  logic [EW-1:0]     push0, push1, kept0, kept1;

  assign in_y      = s_axis_tdata[W-1:0];
  assign in_cb     = s_axis_tdata[2*W-1:W];
  assign in_cr     = s_axis_tdata[3*W-1:2*W];
  assign pair_even = {pend_cr_reg, pend_cb_reg};
  assign pair_odd  = {in_cr, in_cb};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chroma
      if (USE_AVG) begin : g_avg
        logic [W:0] sum;
        assign sum             = {1'b0, pair_even[gi]} + {1'b0, pair_odd[gi]} + {{W{1'b0}}, 1'b1};
        assign chroma_filt[gi] = sum[W:1];
      end else if (gi == 0) begin : g_drop_cb
        assign chroma_filt[gi] = pair_even[gi];
      end else begin : g_drop_cr
        assign chroma_filt[gi] = pair_odd[gi];
      end
    end
  endgenerate

  assign m_axis_tvalid = (count_reg != 2'd0);
  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = q_reg[0];
  assign pop    = m_axis_tvalid & m_axis_tready;
  // Slots free at the next edge, counting a head beat leaving this cycle.
  assign free   = 2'd2 - count_reg + {1'b0, pop};
  assign s_axis_tready = aresetn_q_reg &
                         ((state_reg == EVEN) ? (free >= 2'd1) : (free >= 2'd2));
  assign accept = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_next     = state_reg;
    pend_y_next    = pend_y_reg;
    pend_cb_next   = pend_cb_reg;
    pend_cr_next   = pend_cr_reg;
    pend_user_next = pend_user_reg;
    npush          = 2'd0;
    push0          = '0;
    push1          = '0;
    if (accept) begin
      case (state_reg)
        EVEN: begin
          if (s_axis_tlast) begin
            push0 = {in_cb, in_y, s_axis_tuser, 1'b1};
            npush = 2'd1;
          end else begin
            pend_y_next    = in_y;
            pend_cb_next   = in_cb;
            pend_cr_next   = in_cr;
            pend_user_next = s_axis_tuser;
            state_next     = ODD;
          end
        end
        default: begin
          if (s_axis_tuser) begin
            // SOF mid-pair: flush the orphan pixel unfiltered and restart pairing here.
            push0 = {pend_cb_reg, pend_y_reg, pend_user_reg, 1'b0};
            if (s_axis_tlast) begin
              push1      = {in_cb, in_y, 1'b1, 1'b1};
              npush      = 2'd2;
              state_next = EVEN;
            end else begin
              pend_y_next    = in_y;
              pend_cb_next   = in_cb;
              pend_cr_next   = in_cr;
              pend_user_next = 1'b1;
              npush          = 2'd1;
            end
          end else begin
            push0      = {chroma_filt[0], pend_y_reg, pend_user_reg, 1'b0};
            push1      = {chroma_filt[1], in_y, 1'b0, s_axis_tlast};
            npush      = 2'd2;
            state_next = EVEN;
          end
        end
      endcase
    end
  end

  // Unused queue slots are kept at zero so the outputs read 0 when empty.
  always_comb begin
    kept0     = pop ? q_reg[1] : q_reg[0];
    kept1     = pop ? '0 : q_reg[1];
    kept_cnt  = count_reg - {1'b0, pop};
    q_next[0] = '0;
    q_next[1] = '0;
    case (kept_cnt)
      2'd0: begin
        if (npush != 2'd0) q_next[0] = push0;
        if (npush == 2'd2) q_next[1] = push1;
      end
      2'd1: begin
        q_next[0] = kept0;
        if (npush != 2'd0) q_next[1] = push0;
      end
      default: begin
        q_next[0] = kept0;
        q_next[1] = kept1;
      end
    endcase
    count_next = kept_cnt + npush;
  end

  always_ff @(posedge aclk) begin
    aresetn_q_reg <= aresetn;
    if (!aresetn) begin
      state_reg     <= EVEN;
      pend_y_reg    <= '0;
      pend_cb_reg   <= '0;
      pend_cr_reg   <= '0;
      pend_user_reg <= 1'b0;
      q_reg[0]      <= '0;
      q_reg[1]      <= '0;
      count_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      pend_y_reg    <= pend_y_next;
      pend_cb_reg   <= pend_cb_next;
      pend_cr_reg   <= pend_cr_next;
      pend_user_reg <= pend_user_next;
      q_reg[0]      <= q_next[0];
      q_reg[1]      <= q_next[1];
      count_reg     <= count_next;
    end
  end
endmodule

// File: tb/tb_yuv444_to_yuv422.sv
// Scoreboard bench for yuv444_to_yuv422: directed lines push expected beats,
// monitors pop and compare on every output handshake.
module tb_yuv444_to_yuv422;
  logic        aclk     = 1'b0;
  logic        aresetn  = 1'b0;
  logic [23:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tuser  = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast;
  logic        m_tready = 1'b1;

  logic        drop_en = 1'b0;
  logic        d_s_tvalid, d_s_tready;
  logic [15:0] d_tdata;
  logic        d_tvalid, d_tuser, d_tlast;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] dexp_q[$];

  always #5 aclk = ~aclk;
  assign d_s_tvalid = s_tvalid & drop_en;

  yuv444_to_yuv422 dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast)
  );

  yuv444_to_yuv422 #(.C_CHROMA_MODE("DROP")) dut_drop (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(d_s_tvalid), .s_axis_tready(d_s_tready),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d_tdata), .m_axis_tvalid(d_tvalid), .m_axis_tready(1'b1),
    .m_axis_tuser(d_tuser), .m_axis_tlast(d_tlast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [17:0] beat(input logic [15:0] d, input logic u, input logic l);
    return {d, u, l};
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  // Called at posedge+2; returns at posedge+2 after the beat is accepted.
  task automatic send_px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic u, input logic l, output int waited);
    waited   = 0;
    s_tdata  = {cr, cb, y};
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      #1;
      if (s_tready) begin
        if (drop_en) chk("drop_tready", 32'(d_s_tready), 32'd1);
        @(posedge aclk); #2;
        break;
      end
      @(posedge aclk); #2;
      waited++;
      if (waited > 60) begin
        n_checks++;
        $display("FAIL accept_timeout: pixel y=0x%02h not accepted within 60 clks", y);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                    input logic u, input logic l);
    int w;
    send_px(y, cb, cr, u, l, w);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dexp_q.size() != 0) && t < 100) begin
      @(posedge aclk); #2;
      t++;
    end
    if (exp_q.size() != 0 || dexp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d/%0d beats still outstanding, expected 0/0",
               exp_q.size(), dexp_q.size());
    end
  endtask

  // Main output monitor: handshake compare plus hold-stability under backpressure.
  initial begin : mon
    logic [17:0] cur, held, e;
    bit hold_v;
    hold_v = 0;
    held   = '0;
    forever begin
      @(negedge aclk);
      cur = {m_tdata, m_tuser, m_tlast};
      if (!aresetn) begin
        hold_v = 0;
        continue;
      end
      if (hold_v) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        if (m_tvalid) chk("hold_stable", 32'(cur), 32'(held));
      end
      hold_v = 0;
      if (m_tvalid && m_tready) begin
        $display("avg beat tdata=0x%04h tuser=%0b tlast=%0b", m_tdata, m_tuser, m_tlast);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got 0x%05h, expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          chk("avg_beat", 32'(cur), 32'(e));
        end
      end else if (m_tvalid) begin
        hold_v = 1;
        held   = cur;
      end
    end
  end

  initial begin : mon_drop
    logic [17:0] cur, e;
    forever begin
      @(negedge aclk);
      if (aresetn && d_tvalid) begin
        cur = {d_tdata, d_tuser, d_tlast};
        $display("drop beat tdata=0x%04h tuser=%0b tlast=%0b", d_tdata, d_tuser, d_tlast);
        if (dexp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_drop_beat: got 0x%05h, expected no beat", cur);
        end else begin
          e = dexp_q.pop_front();
          chk("drop_beat", 32'(cur), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    logic [7:0] ys [6];
    logic [7:0] cbs [6];
    logic [7:0] crs [6];

    // Reset state
    repeat (3) @(posedge aclk);
    #3;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_tdata),  32'd0);
    chk("rst_m_tuser",  32'(m_tuser),  32'd0);
    chk("rst_m_tlast",  32'(m_tlast),  32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    @(posedge aclk); #2;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #2;

    // AVG 4-pixel line at full rate
    exp_q.push_back(beat(16'h650A, 1'b1, 1'b0));
    exp_q.push_back(beat(16'hC90B, 1'b0, 1'b0));
    exp_q.push_back(beat(16'h330C, 1'b0, 1'b0));
    exp_q.push_back(beat(16'h3D0D, 1'b0, 1'b1));
    send_px(8'd10, 8'd100, 8'd200, 1'b1, 1'b0, w); chk("tput_px0", 32'(w), 32'd0);
    send_px(8'd11, 8'd101, 8'd202, 1'b0, 1'b0, w); chk("tput_px1", 32'(w), 32'd0);
    send_px(8'd12, 8'd50,  8'd60,  1'b0, 1'b0, w); chk("tput_px2", 32'(w), 32'd0);
    send_px(8'd13, 8'd52,  8'd61,  1'b0, 1'b1, w); chk("tput_px3", 32'(w), 32'd0);
    drain();

    // Odd-length line: last pixel emitted alone with its own Cb
    exp_q.push_back(beat(16'h650A, 1'b1, 1'b0));
    exp_q.push_back(beat(16'hC90B, 1'b0, 1'b0));
    exp_q.push_back(beat(16'h320C, 1'b0, 1'b1));
    px(8'd10, 8'd100, 8'd200, 1'b1, 1'b0);
    px(8'd11, 8'd101, 8'd202, 1'b0, 1'b0);
    px(8'd12, 8'd50,  8'd60,  1'b0, 1'b1);
    drain();

    // DROP instance alongside AVG on the same 4 pixels
    drop_en = 1'b1;
    exp_q.push_back(beat(16'h650A, 1'b1, 1'b0));
    exp_q.push_back(beat(16'hC90B, 1'b0, 1'b0));
    exp_q.push_back(beat(16'h330C, 1'b0, 1'b0));
    exp_q.push_back(beat(16'h3D0D, 1'b0, 1'b1));
    dexp_q.push_back(beat(16'h640A, 1'b1, 1'b0));
    dexp_q.push_back(beat(16'hCA0B, 1'b0, 1'b0));
    dexp_q.push_back(beat(16'h320C, 1'b0, 1'b0));
    dexp_q.push_back(beat(16'h3D0D, 1'b0, 1'b1));
    px(8'd10, 8'd100, 8'd200, 1'b1, 1'b0);
    px(8'd11, 8'd101, 8'd202, 1'b0, 1'b0);
    px(8'd12, 8'd50,  8'd60,  1'b0, 1'b0);
    px(8'd13, 8'd52,  8'd61,  1'b0, 1'b1);
    drain();
    drop_en = 1'b0;

    // Backpressure: m_tready low for 5 clks in the middle of a 6-pixel line
    for (int i = 0; i < 6; i++) begin
      ys[i]  = 8'(8'h40 + i);
      cbs[i] = 8'(16*i + 3);
      crs[i] = 8'(200 - 7*i);
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(beat({avg8(cbs[2*k], cbs[2*k+1]), ys[2*k]}, (k == 0), 1'b0));
      exp_q.push_back(beat({avg8(crs[2*k], crs[2*k+1]), ys[2*k+1]}, 1'b0, (k == 2)));
    end
    fork
      begin
        for (int i = 0; i < 6; i++) px(ys[i], cbs[i], crs[i], (i == 0), (i == 5));
      end
      begin
        repeat (2) @(posedge aclk);
        #2 m_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("bp_s_tready_low", 32'(s_tready), 32'd0);
        chk("bp_m_tvalid_high", 32'(m_tvalid), 32'd1);
        #1;
        repeat (2) @(posedge aclk);
        #2 m_tready = 1'b1;
      end
    join
    drain();

    // SOF arriving mid-pair
    exp_q.push_back(beat(16'h5014, 1'b0, 1'b0));
    exp_q.push_back(beat(16'h2915, 1'b1, 1'b0));
    exp_q.push_back(beat(16'h3416, 1'b0, 1'b1));
    px(8'd20, 8'd80, 8'd90, 1'b0, 1'b0);
    px(8'd21, 8'd40, 8'd50, 1'b1, 1'b0);
    px(8'd22, 8'd42, 8'd53, 1'b0, 1'b1);
    drain();

    // Reset with one beat queued and an even pixel pending
    exp_q.push_back(beat(16'h0401, 1'b1, 1'b0));
    exp_q.push_back(beat(16'h0604, 1'b0, 1'b0));
    px(8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
    px(8'd4, 8'd6, 8'd8, 1'b0, 1'b0);
    px(8'd9, 8'd9, 8'd9, 1'b0, 1'b0);
    m_tready = 1'b0;
    aresetn  = 1'b0;
    exp_q.delete();
    @(posedge aclk); #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    chk("midrst_m_tdata",  32'(m_tdata),  32'd0);
    #1;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    @(posedge aclk); #2;
    exp_q.push_back(beat(16'h0B1E, 1'b1, 1'b0));
    exp_q.push_back(beat(16'h151F, 1'b0, 1'b1));
    px(8'd30, 8'd10, 8'd20, 1'b1, 1'b0);
    px(8'd31, 8'd12, 8'd22, 1'b0, 1'b1);
    drain();
    repeat (5) @(posedge aclk);
    #2;
    chk("final_m_tvalid", 32'(m_tvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
